// File: rtl/vector_memory_unit.sv
// vector_memory_unit: dual-read/single-write word memory with a zero-clear sweep on reset or load.
// Reads are registered (latency 1) with write-first bypass; rejected requests pulse err.
module vector_memory_unit #(
  parameter int WORD_SIZE  = 24,
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  output logic                  busy,
  input  logic                  rd_en1,
  input  logic                  rd_en2,
  input  logic [ADDR_WIDTH-1:0] address1,
  input  logic [ADDR_WIDTH-1:0] address2,
  output logic [WORD_SIZE-1:0]  data_out1,
  output logic [WORD_SIZE-1:0]  data_out2,
  output logic                  rd_valid1,
  output logic                  rd_valid2,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_SIZE-1:0]  wr_data,
  output logic                  err
);
  localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(DEPTH-1);
  typedef enum logic {CLEAR, READY} state_t;
  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_ptr, w_clr_ptr_nxt;
  logic [WORD_SIZE-1:0]  r_mem [DEPTH];
  logic                  w_ready, w_rd_ok1, w_rd_ok2, w_wr_ok;
  assign w_ready  = r_state == READY;
  assign busy     = ~w_ready;
  assign w_rd_ok1 = w_ready & rd_en1 & ({1'b0, address1} < LP_DEPTH);
  assign w_rd_ok2 = w_ready & rd_en2 & ({1'b0, address2} < LP_DEPTH);
  assign w_wr_ok  = w_ready & wr_en  & ({1'b0, wr_addr}  < LP_DEPTH);
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    if (load) begin
      w_state_nxt   = CLEAR;
      w_clr_ptr_nxt = '0;
    end else if (r_state == CLEAR) begin
      w_state_nxt   = (r_clr_ptr == LP_LAST) ? READY : CLEAR;
      w_clr_ptr_nxt = (r_clr_ptr == LP_LAST) ? '0 : r_clr_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
      data_out1 <= '0;
      data_out2 <= '0;
      rd_valid1 <= 1'b0;
      rd_valid2 <= 1'b0;
      err       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
      data_out1 <= !w_rd_ok1 ? data_out1 : (w_wr_ok && wr_addr == address1) ? wr_data : r_mem[address1];
      data_out2 <= !w_rd_ok2 ? data_out2 : (w_wr_ok && wr_addr == address2) ? wr_data : r_mem[address2];
      rd_valid1 <= w_rd_ok1;
      rd_valid2 <= w_rd_ok2;
      // any enabled request that was not accepted is a rejection
      err       <= (rd_en1 & ~w_rd_ok1) | (rd_en2 & ~w_rd_ok2) | (wr_en & ~w_wr_ok);
    end
  end
  always_ff @(posedge clk) begin
    if (!w_ready) r_mem[r_clr_ptr] <= '0;
    else if (w_wr_ok) r_mem[wr_addr] <= wr_data;
  end
endmodule

// File: tb/tb_vector_memory_unit.sv
// tb_vector_memory_unit: scoreboarded bench with a DEPTH=16 instance and a DEPTH=12 instance for range rejection.
module tb_vector_memory_unit;
  localparam int AW = 4, W = 24, D = 16;
  logic clk = 0, rst_n = 0, load = 0, rd_en1 = 0, rd_en2 = 0, wr_en = 0;
  logic [AW-1:0] address1 = 0, address2 = 0, wr_addr = 0;
  logic [W-1:0]  wr_data = 0;
  logic busy, rd_valid1, rd_valid2, err;
  logic [W-1:0] data_out1, data_out2;
  logic busy12, rd_valid1_12, rd_valid2_12, err12;
  logic [W-1:0] data_out1_12, data_out2_12;
  vector_memory_unit #(.WORD_SIZE(W), .ADDR_WIDTH(AW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .busy(busy),
    .rd_en1(rd_en1), .rd_en2(rd_en2), .address1(address1), .address2(address2),
    .data_out1(data_out1), .data_out2(data_out2), .rd_valid1(rd_valid1), .rd_valid2(rd_valid2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .err(err));
  vector_memory_unit #(.WORD_SIZE(W), .ADDR_WIDTH(AW), .DEPTH(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .load(load), .busy(busy12),
    .rd_en1(rd_en1), .rd_en2(rd_en2), .address1(address1), .address2(address2),
    .data_out1(data_out1_12), .data_out2(data_out2_12), .rd_valid1(rd_valid1_12), .rd_valid2(rd_valid2_12),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .err(err12));
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [W-1:0] m [D];
  bit m_ready = 0;
  int m_ptr = 0;
  logic [W-1:0] m_d1 = 0, m_d2 = 0;
  logic [W-1:0] q1 [$];
  logic [W-1:0] q2 [$];

  typedef struct {
    logic we; logic [AW-1:0] wa; logic [W-1:0] wd;
    logic r1; logic [AW-1:0] a1; logic r2; logic [AW-1:0] a2;
    logic [W-1:0] d1; logic [W-1:0] d2; logic v1; logic v2; logic e;
  } vec_t;
  vec_t tv [6];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic idle();
    load = 0; rd_en1 = 0; rd_en2 = 0; wr_en = 0;
  endtask

  // one clock: model predicts from current inputs, DUT outputs compared #1 after the edge
  task automatic tick();
    bit e1, e2, ew, ee;
    e1 = m_ready && rd_en1 && int'(address1) < D;
    e2 = m_ready && rd_en2 && int'(address2) < D;
    ew = m_ready && wr_en && int'(wr_addr) < D;
    ee = (rd_en1 && !e1) || (rd_en2 && !e2) || (wr_en && !ew);
    if (e1) q1.push_back((ew && wr_addr == address1) ? wr_data : m[address1]);
    if (e2) q2.push_back((ew && wr_addr == address2) ? wr_data : m[address2]);
    if (ew) m[wr_addr] = wr_data;
    if (!m_ready) m[m_ptr] = '0;
    if (load) begin
      m_ready = 0; m_ptr = 0;
    end else if (!m_ready) begin
      if (m_ptr == D-1) begin m_ready = 1; m_ptr = 0; end
      else m_ptr++;
    end
    @(posedge clk); #1;
    chk("busy", busy, 32'(!m_ready));
    chk("err", err, 32'(ee));
    chk("valid1", rd_valid1, 32'(e1));
    chk("valid2", rd_valid2, 32'(e2));
    if (rd_valid1) begin
      if (q1.size() == 0) begin checks++; errors++; $display("FAIL sb1: valid with empty queue"); end
      else m_d1 = q1.pop_front();
    end
    if (rd_valid2) begin
      if (q2.size() == 0) begin checks++; errors++; $display("FAIL sb2: valid with empty queue"); end
      else m_d2 = q2.pop_front();
    end
    chk("data1", data_out1, 32'(m_d1));
    chk("data2", data_out2, 32'(m_d2));
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    idle();
    m_ready = 0; m_ptr = 0; m_d1 = 0; m_d2 = 0;
    q1.delete(); q2.delete();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_busy", busy, 1); chk("rst_err", err, 0);
    chk("rst_v1", rd_valid1, 0); chk("rst_v2", rd_valid2, 0);
    chk("rst_d1", data_out1, 0); chk("rst_d2", data_out2, 0);
    chk("rst_busy12", busy12, 1);
    rst_n = 1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin tick(); n++; end
  endtask

  task automatic read_all();
    for (int i = 0; i < D; i++) begin
      rd_en1 = 1; address1 = AW'(i); rd_en2 = 1; address2 = AW'(D-1-i);
      tick();
    end
    idle();
  endtask

  initial begin
    int n;
    for (int i = 0; i < D; i++) m[i] = '0;
    tv[0] = '{1'b1, 4'd5, 24'hABCDEF, 1'b0, 4'd0, 1'b0, 4'd0, 24'h0,      24'h0,      1'b0, 1'b0, 1'b0};
    tv[1] = '{1'b0, 4'd0, 24'h0,      1'b1, 4'd5, 1'b1, 4'd6, 24'hABCDEF, 24'h0,      1'b1, 1'b1, 1'b0};
    tv[2] = '{1'b1, 4'd3, 24'h000111, 1'b1, 4'd3, 1'b0, 4'd0, 24'h000111, 24'h0,      1'b1, 1'b0, 1'b0};
    tv[3] = '{1'b0, 4'd0, 24'h0,      1'b0, 4'd0, 1'b0, 4'd0, 24'h000111, 24'h0,      1'b0, 1'b0, 1'b0};
    tv[4] = '{1'b0, 4'd0, 24'h0,      1'b1, 4'd5, 1'b1, 4'd5, 24'hABCDEF, 24'hABCDEF, 1'b1, 1'b1, 1'b0};
    tv[5] = '{1'b1, 4'd7, 24'h5A5A5A, 1'b0, 4'd0, 1'b1, 4'd7, 24'hABCDEF, 24'h5A5A5A, 1'b0, 1'b1, 1'b0};
    @(posedge clk); #1;
    do_reset();
    count_busy(n);
    chk("reset_sweep_len", 32'(n), 16);
    read_all();
    for (int i = 0; i < 6; i++) begin
      wr_en = tv[i].we; wr_addr = tv[i].wa; wr_data = tv[i].wd;
      rd_en1 = tv[i].r1; address1 = tv[i].a1; rd_en2 = tv[i].r2; address2 = tv[i].a2;
      tick();
      chk($sformatf("vec%0d_d1", i), data_out1, 32'(tv[i].d1));
      chk($sformatf("vec%0d_d2", i), data_out2, 32'(tv[i].d2));
      chk($sformatf("vec%0d_v1", i), rd_valid1, 32'(tv[i].v1));
      chk($sformatf("vec%0d_v2", i), rd_valid2, 32'(tv[i].v2));
      chk($sformatf("vec%0d_err", i), err, 32'(tv[i].e));
    end
    idle();
    // load, then write and read while clearing
    load = 1; tick(); idle();
    wr_en = 1; wr_addr = 4'd5; wr_data = 24'hFFFFFF; tick(); idle();
    chk("busy_wr_err", err, 1);
    tick();
    chk("busy_err_once", err, 0);
    rd_en2 = 1; address2 = 4'd2; tick(); idle();
    chk("busy_rd_err", err, 1); chk("busy_rd_v2", rd_valid2, 0);
    count_busy(n);
    chk("load_sweep_len", 32'(n + 3), 16);
    read_all();
    // reload mid-sweep
    load = 1; tick(); idle();
    n = 1;
    while (busy && n < 200) begin load = (n == 9); tick(); n++; end
    idle();
    chk("reload_sweep_len", 32'(n), 26);
    // reset with a read pending
    wr_en = 1; wr_addr = 4'd5; wr_data = 24'h777777; tick(); idle();
    rd_en1 = 1; address1 = 4'd5;
    do_reset();
    count_busy(n);
    chk("rst2_sweep_len", 32'(n), 16);
    rd_en1 = 1; address1 = 4'd5; tick(); idle();
    chk("rst2_rd5", data_out1, 0);
    // out-of-range on the DEPTH=12 instance
    wr_en = 1; wr_addr = 4'd2; wr_data = 24'h123456; tick(); idle();
    rd_en1 = 1; address1 = 4'd2; tick(); idle();
    chk("d12_rd_d1", data_out1_12, 32'h123456); chk("d12_rd_v1", rd_valid1_12, 1);
    rd_en1 = 1; address1 = 4'd13; tick(); idle();
    chk("d12_oor_err", err12, 1); chk("d12_oor_v1", rd_valid1_12, 0);
    chk("d12_oor_hold", data_out1_12, 32'h123456);
    tick();
    chk("d12_err_once", err12, 0);
    chk("q1_empty", 32'(q1.size()), 0);
    chk("q2_empty", 32'(q2.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
